// File: rtl/render_pkg.sv
// rtl/render_pkg.sv - shared FSM state type and screen/colour constants for particle_renderer
package render_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FETCH,
        WAIT,
        DRAW,
        DONE
    } render_state_t;

    localparam int SCREEN_W = 64;
    localparam int SCREEN_H = 64;
    localparam int COLOR_W  = 3;
    localparam logic [COLOR_W-1:0] COLOR_OFF = 3'b000;

endpackage

// File: rtl/particle_renderer.sv
// rtl/particle_renderer.sv - 64x64 frame clear plus per-particle pixel plotter feeding the HUB75 write port
// Optional 2x2 blob drawing with edge clipping when RENDER_BLOB_EN is defined.
module particle_renderer
    import render_pkg::*;
#(
    parameter int                 N_PARTICLES = 16,
    parameter logic [COLOR_W-1:0] CLEAR_COLOR = 3'b000,
    localparam int                AW          = (N_PARTICLES > 1) ? $clog2(N_PARTICLES) : 1
) (
    input  logic               clk_in,
    input  logic               reset,
    input  logic               frame_start,
    output logic               busy,
    output logic               done,
    output logic               p_rd_en,
    output logic [AW-1:0]      p_addr,
    input  logic [5:0]         p_x,
    input  logic [5:0]         p_y,
    input  logic [COLOR_W-1:0] p_color,
    output logic               write_en,
    output logic [5:0]         write_x,
    output logic [5:0]         write_y,
    output logic [COLOR_W-1:0] write_color
);

    localparam logic [11:0]   CNT_LAST = 12'(SCREEN_W * SCREEN_H - 1);
    localparam logic [AW-1:0] IDX_LAST = AW'(N_PARTICLES - 1);
`ifdef RENDER_BLOB_EN
    localparam logic [1:0]    SUB_LAST = 2'd3;
`else
    localparam logic [1:0]    SUB_LAST = 2'd0;
`endif

    render_state_t      r_state, w_state_n;
    logic [11:0]        r_cnt, w_cnt_n;
    logic [AW-1:0]      r_idx, w_idx_n;
    logic [1:0]         r_sub, w_sub_n;
    logic [5:0]         r_px, r_py;
    logic [COLOR_W-1:0] r_pc;

    logic               r_busy, r_done, r_p_rd_en, r_write_en;
    logic [AW-1:0]      r_p_addr;
    logic [5:0]         r_write_x, r_write_y;
    logic [COLOR_W-1:0] r_write_color;

    logic               w_busy, w_done, w_p_rd_en, w_write_en;
    logic [AW-1:0]      w_p_addr;
    logic [5:0]         w_write_x, w_write_y;
    logic [COLOR_W-1:0] w_write_color;
    logic [5:0]         w_base_x, w_base_y;
    logic [COLOR_W-1:0] w_base_c;
    logic [6:0]         w_sum_x, w_sum_y;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_idx         <= '0;
            r_sub         <= '0;
            r_px          <= '0;
            r_py          <= '0;
            r_pc          <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_p_rd_en     <= 1'b0;
            r_p_addr      <= '0;
            r_write_en    <= 1'b0;
            r_write_x     <= '0;
            r_write_y     <= '0;
            r_write_color <= '0;
        end else begin
            r_state       <= w_state_n;
            r_cnt         <= w_cnt_n;
            r_idx         <= w_idx_n;
            r_sub         <= w_sub_n;
            if (r_state == WAIT) begin
                r_px <= p_x;
                r_py <= p_y;
                r_pc <= p_color;
            end
            r_busy        <= w_busy;
            r_done        <= w_done;
            r_p_rd_en     <= w_p_rd_en;
            r_p_addr      <= w_p_addr;
            r_write_en    <= w_write_en;
            r_write_x     <= w_write_x;
            r_write_y     <= w_write_y;
            r_write_color <= w_write_color;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_idx_n   = r_idx;
        w_sub_n   = r_sub;
        case (r_state)
            IDLE: begin
                if (frame_start) begin
                    w_state_n = CLEAR;
                    w_cnt_n   = '0;
                    w_idx_n   = '0;
                end
            end
            CLEAR: begin
                if (r_cnt == CNT_LAST) w_state_n = FETCH;
                else                   w_cnt_n   = r_cnt + 12'd1;
            end
            FETCH: w_state_n = WAIT;
            WAIT: begin
                w_state_n = DRAW;
                w_sub_n   = '0;
            end
            DRAW: begin
                if (r_sub != SUB_LAST) begin
                    w_sub_n = r_sub + 2'd1;
                end else if (r_idx == IDX_LAST) begin
                    w_state_n = DONE;
                end else begin
                    w_idx_n   = r_idx + AW'(1);
                    w_state_n = FETCH;
                end
            end
            DONE:    w_state_n = IDLE;
            default: w_state_n = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it;
    // the first DRAW cycle takes the particle straight from the RAM data bus.
    always_comb begin
        w_base_x      = (r_state == WAIT) ? p_x     : r_px;
        w_base_y      = (r_state == WAIT) ? p_y     : r_py;
        w_base_c      = (r_state == WAIT) ? p_color : r_pc;
        w_sum_x       = {1'b0, w_base_x} + {6'd0, w_sub_n[0]};
        w_sum_y       = {1'b0, w_base_y} + {6'd0, w_sub_n[1]};
        w_busy        = (w_state_n != IDLE);
        w_done        = 1'b0;
        w_p_rd_en     = 1'b0;
        w_p_addr      = '0;
        w_write_en    = 1'b0;
        w_write_x     = '0;
        w_write_y     = '0;
        w_write_color = '0;
        case (w_state_n)
            CLEAR: begin
                w_write_en    = 1'b1;
                w_write_x     = w_cnt_n[5:0];
                w_write_y     = w_cnt_n[11:6];
                w_write_color = CLEAR_COLOR;
            end
            FETCH: begin
                w_p_rd_en = 1'b1;
                w_p_addr  = w_idx_n;
            end
            DRAW: begin
                w_write_en    = (w_base_c != COLOR_OFF) &&
                                (w_sum_x < 7'(SCREEN_W)) && (w_sum_y < 7'(SCREEN_H));
                w_write_x     = w_sum_x[5:0];
                w_write_y     = w_sum_y[5:0];
                w_write_color = w_base_c;
            end
            DONE:    w_done = 1'b1;
            default: ;
        endcase
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign p_rd_en     = r_p_rd_en;
    assign p_addr      = r_p_addr;
    assign write_en    = r_write_en;
    assign write_x     = r_write_x;
    assign write_y     = r_write_y;
    assign write_color = r_write_color;

endmodule

// File: tb/tb_particle_renderer.sv
// tb/tb_particle_renderer.sv - directed self-checking bench for particle_renderer
module tb_particle_renderer;

`ifdef RENDER_BLOB_EN
    localparam int SPAN = 4096 + 6 * 16 + 1;
`else
    localparam int SPAN = 4096 + 3 * 16 + 1;
`endif

    logic       clk_in = 1'b0;
    logic       reset = 1'b1;
    logic       frame_start = 1'b0;
    logic       busy, done, p_rd_en, write_en;
    logic [3:0] p_addr;
    logic [5:0] p_x = '0, p_y = '0, write_x, write_y;
    logic [2:0] p_color = '0, write_color;

    logic [5:0] ram_x [16];
    logic [5:0] ram_y [16];
    logic [2:0] ram_c [16];

    int n_checks = 0;
    int n_errors = 0;

    int f_busy, f_done_cyc, f_dones, f_clear_bad, f_draws, f_end_cyc, f_fin;
    logic [14:0] f_first, f_last;

    particle_renderer #(.N_PARTICLES(16), .CLEAR_COLOR(3'b000)) dut (
        .clk_in(clk_in), .reset(reset), .frame_start(frame_start),
        .busy(busy), .done(done), .p_rd_en(p_rd_en), .p_addr(p_addr),
        .p_x(p_x), .p_y(p_y), .p_color(p_color),
        .write_en(write_en), .write_x(write_x), .write_y(write_y), .write_color(write_color)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) begin
        if (p_rd_en) begin
            p_x     <= ram_x[p_addr];
            p_y     <= ram_y[p_addr];
            p_color <= ram_c[p_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic clear_particles();
        for (int i = 0; i < 16; i++) begin
            ram_x[i] = 6'(i);
            ram_y[i] = 6'(i + 1);
            ram_c[i] = 3'd0;
        end
    endtask

    // mode 0: plain frame, 1: extra frame_start pulses in CLEAR and DRAW, 2: reset at clear count 1000
    task automatic run_frame(input int mode);
        int cyc;
        f_busy = 0; f_done_cyc = 0; f_dones = 0; f_clear_bad = 0; f_draws = 0;
        f_end_cyc = 0; f_fin = 0; f_first = '0; f_last = '0;
        frame_start = 1'b1;
        cyc = 0;
        while (f_fin == 0 && cyc < 6000) begin
            @(negedge clk_in);
            cyc++;
            frame_start = 1'b0;
            if (busy) f_busy++;
            if (cyc <= 4096 && !(write_en && write_color == 3'd0 &&
                                 write_x == 6'(cyc - 1) && write_y == 6'((cyc - 1) >> 6)))
                f_clear_bad++;
            if (cyc > 4096 && write_en) begin
                if (f_draws == 0) f_first = {write_x, write_y, write_color};
                f_last = {write_x, write_y, write_color};
                f_draws++;
            end
            if (done) begin
                f_dones++;
                f_done_cyc = cyc;
            end
            if (mode == 1 && (cyc == 100 || cyc == 4099)) frame_start = 1'b1;
            if (mode == 2 && cyc == 1001) begin
                check("rst_pre_we", write_en, 1);
                check("rst_pre_x", write_x, 40);
                check("rst_pre_y", write_y, 15);
                reset = 1'b1;
            end else if (mode == 2 && cyc == 1002) begin
                check("rst_we_low", write_en, 0);
                check("rst_busy_low", busy, 0);
                reset = 1'b0;
                f_fin = 1;
            end else if (mode != 2 && cyc > 1 && !busy) begin
                f_fin = 1;
            end
            f_end_cyc = cyc;
        end
        check("frame_timeout", f_fin, 1);
    endtask

    task automatic check_frame(input string tag, input int draws, input logic [14:0] first,
                               input logic [14:0] last);
        check({tag, "_clear_seq"}, f_clear_bad, 0);
        check({tag, "_busy_span"}, f_busy, SPAN);
        check({tag, "_done_cyc"}, f_done_cyc, SPAN);
        check({tag, "_done_cnt"}, f_dones, 1);
        check({tag, "_busy_fall"}, f_end_cyc, SPAN + 1);
        check({tag, "_draws"}, draws == f_draws, 1);
        if (draws > 0) begin
            check({tag, "_first"}, f_first, first);
            check({tag, "_last"}, f_last, last);
        end
    endtask

    initial begin
        int idle_busy;
        clear_particles();
        repeat (3) @(negedge clk_in);
        check("reset_outputs", {busy, done, p_rd_en, p_addr, write_en, write_x, write_y, write_color}, 0);
        reset = 1'b0;
        @(negedge clk_in);

        // particle 0 only
        ram_x[0] = 6'd10; ram_y[0] = 6'd20; ram_c[0] = 3'd5;
`ifdef RENDER_BLOB_EN
        run_frame(0);
        check_frame("p0", 4, {6'd10, 6'd20, 3'd5}, {6'd11, 6'd21, 3'd5});
        run_frame(0);
        check_frame("b2b", 4, {6'd10, 6'd20, 3'd5}, {6'd11, 6'd21, 3'd5});
`else
        run_frame(0);
        check_frame("p0", 1, {6'd10, 6'd20, 3'd5}, {6'd10, 6'd20, 3'd5});
        run_frame(0);
        check_frame("b2b", 1, {6'd10, 6'd20, 3'd5}, {6'd10, 6'd20, 3'd5});
`endif

        // no particles, stray starts during CLEAR and DRAW
        clear_particles();
        repeat (3) @(negedge clk_in);
        run_frame(1);
        check_frame("ignore", 0, '0, '0);
        idle_busy = 0;
        repeat (5) begin
            @(negedge clk_in);
            if (busy) idle_busy++;
        end
        check("not_queued", idle_busy, 0);

        // reset during CLEAR then a clean restart
        run_frame(2);
        check("rst_no_done", f_dones, 0);
        repeat (3) @(negedge clk_in);
        check("rst_idle", {busy, done, write_en}, 0);
        run_frame(0);
        check_frame("restart", 0, '0, '0);

        // last particle at the corner: blob variant clips three of four writes
        ram_x[15] = 6'd63; ram_y[15] = 6'd63; ram_c[15] = 3'd7;
        repeat (2) @(negedge clk_in);
        run_frame(0);
        check_frame("corner", 1, {6'd63, 6'd63, 3'd7}, {6'd63, 6'd63, 3'd7});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
